// File: rtl/cellrv32_vmu_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : cellrv32_vmu_mem_bridge
// Brief    : Bridges VMU load/store requests to a single-beat data bus.
//            Requests are queued in order and issued to the bus. Load data
//            returns to the VMU in order with its ticket.
//            Optional bus-error reporting is enabled by defining VMU_BRIDGE_ERR_EN.
// Revision : 1.0 - initial release
// ============================================================================
module cellrv32_vmu_mem_bridge #(
    parameter int REQ_DEPTH      = 4,
    parameter int MAX_OUT        = 4,
    parameter int ADDR_WIDTH     = 32,
    parameter int REQ_DATA_WIDTH = 32,
    parameter int TICKET_WIDTH   = 4,
    parameter int MICROOP_WIDTH  = 5,
    parameter logic [MICROOP_WIDTH-1:0] OPCODE_VSTORE = 5'b00101
) (
    input  logic                                                             clk,
    input  logic                                                             rst_n,
    input  logic                                                             mem_req_valid_i,
    input  logic [ADDR_WIDTH+MICROOP_WIDTH+TICKET_WIDTH+REQ_DATA_WIDTH-1:0]  mem_req_i,
    output logic                                                             mem_req_ready_o,
    output logic                                                             mem_resp_valid_o,
    output logic [TICKET_WIDTH+REQ_DATA_WIDTH-1:0]                           mem_resp_o,
    output logic                                                             bus_req_o,
    output logic                                                             bus_we_o,
    output logic [ADDR_WIDTH-1:0]                                            bus_addr_o,
    output logic [REQ_DATA_WIDTH-1:0]                                        bus_wdata_o,
    input  logic                                                             bus_gnt_i,
    input  logic                                                             bus_ack_i,
    input  logic [REQ_DATA_WIDTH-1:0]                                        bus_rdata_i,
    input  logic                                                             bus_err_i,
    output logic                                                             err_o,
    output logic                                                             idle_o
);

    localparam int c_req_w   = ADDR_WIDTH + MICROOP_WIDTH + TICKET_WIDTH + REQ_DATA_WIDTH;
    localparam int c_entry_w = 1 + ADDR_WIDTH + REQ_DATA_WIDTH + TICKET_WIDTH;
    localparam int c_rptr_w  = (REQ_DEPTH > 1) ? $clog2(REQ_DEPTH) : 1;
    localparam int c_rcnt_w  = $clog2(REQ_DEPTH + 1);
    localparam int c_tptr_w  = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int c_tcnt_w  = $clog2(MAX_OUT + 1);
    localparam logic [c_rptr_w-1:0] c_rptr_last = c_rptr_w'(REQ_DEPTH - 1);
    localparam logic [c_tptr_w-1:0] c_tptr_last = c_tptr_w'(MAX_OUT - 1);
    localparam logic [c_rcnt_w-1:0] c_rcnt_full = c_rcnt_w'(REQ_DEPTH);
    localparam logic [c_tcnt_w-1:0] c_tcnt_full = c_tcnt_w'(MAX_OUT);

    // Request entry: {we, addr, data, ticket}; tracker entry: {is_load, ticket}
    logic [c_entry_w-1:0]      r_req_mem [REQ_DEPTH];
    logic [TICKET_WIDTH:0]     r_trk_mem [MAX_OUT];
    logic [c_rptr_w-1:0]       r_req_wr, r_req_rd;
    logic [c_rcnt_w-1:0]       r_req_cnt;
    logic [c_tptr_w-1:0]       r_trk_wr, r_trk_rd;
    logic [c_tcnt_w-1:0]       r_trk_cnt;
    logic                      r_resp_valid;
    logic [TICKET_WIDTH+REQ_DATA_WIDTH-1:0] r_resp;

    logic [ADDR_WIDTH-1:0]     w_req_addr;
    logic [MICROOP_WIDTH-1:0]  w_req_op;
    logic [TICKET_WIDTH-1:0]   w_req_ticket;
    logic [REQ_DATA_WIDTH-1:0] w_req_data;
    logic [c_entry_w-1:0]      w_head;
    logic [TICKET_WIDTH:0]     w_trk_head;
    logic [REQ_DATA_WIDTH-1:0] w_rdata;
    logic                      w_req_full, w_req_empty, w_trk_full, w_trk_empty;
    logic                      w_push, w_issue, w_ack;

    assign w_req_addr   = mem_req_i[c_req_w-1 -: ADDR_WIDTH];
    assign w_req_op     = mem_req_i[TICKET_WIDTH+REQ_DATA_WIDTH +: MICROOP_WIDTH];
    assign w_req_ticket = mem_req_i[REQ_DATA_WIDTH +: TICKET_WIDTH];
    assign w_req_data   = mem_req_i[REQ_DATA_WIDTH-1:0];

    assign w_req_full  = (r_req_cnt == c_rcnt_full);
    assign w_req_empty = (r_req_cnt == '0);
    assign w_trk_full  = (r_trk_cnt == c_tcnt_full);
    assign w_trk_empty = (r_trk_cnt == '0);

    assign w_head     = r_req_mem[r_req_rd];
    assign w_trk_head = r_trk_mem[r_trk_rd];

    assign mem_req_ready_o = ~w_req_full;
    // Issue is gated by the pre-ack tracker state: no issue-through-pop
    assign bus_req_o       = ~w_req_empty & ~w_trk_full;
    assign bus_we_o        = w_head[c_entry_w-1];
    assign bus_addr_o      = w_head[c_entry_w-2 -: ADDR_WIDTH];
    assign bus_wdata_o     = w_head[TICKET_WIDTH +: REQ_DATA_WIDTH];

    assign w_push  = mem_req_valid_i & ~w_req_full;
    assign w_issue = bus_req_o & bus_gnt_i;
    assign w_ack   = bus_ack_i & ~w_trk_empty;

    assign mem_resp_valid_o = r_resp_valid;
    assign mem_resp_o       = r_resp;
    assign idle_o           = w_req_empty & w_trk_empty;

`ifdef VMU_BRIDGE_ERR_EN
    logic r_err;
    assign w_rdata = bus_err_i ? '0 : bus_rdata_i;
    assign err_o   = r_err;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (bus_ack_i & (bus_err_i | w_trk_empty)) begin
            r_err <= 1'b1;
        end
    end
`else
    logic w_unused_err;
    assign w_unused_err = bus_err_i;
    assign w_rdata      = bus_rdata_i;
    assign err_o        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_req_mem[r_req_wr] <= {(w_req_op == OPCODE_VSTORE), w_req_addr, w_req_data, w_req_ticket};
        end
        if (w_issue) begin
            r_trk_mem[r_trk_wr] <= {~bus_we_o, w_head[TICKET_WIDTH-1:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_req_wr     <= '0;
            r_req_rd     <= '0;
            r_req_cnt    <= '0;
            r_trk_wr     <= '0;
            r_trk_rd     <= '0;
            r_trk_cnt    <= '0;
            r_resp_valid <= 1'b0;
            r_resp       <= '0;
        end else begin
            if (w_push) begin
                r_req_wr <= (r_req_wr == c_rptr_last) ? '0 : r_req_wr + 1'b1;
            end
            if (w_issue) begin
                r_req_rd <= (r_req_rd == c_rptr_last) ? '0 : r_req_rd + 1'b1;
                r_trk_wr <= (r_trk_wr == c_tptr_last) ? '0 : r_trk_wr + 1'b1;
            end
            if (w_ack) begin
                r_trk_rd <= (r_trk_rd == c_tptr_last) ? '0 : r_trk_rd + 1'b1;
            end

            case ({w_push, w_issue})
                2'b10:   r_req_cnt <= r_req_cnt + 1'b1;
                2'b01:   r_req_cnt <= r_req_cnt - 1'b1;
                default: r_req_cnt <= r_req_cnt;
            endcase

            case ({w_issue, w_ack})
                2'b10:   r_trk_cnt <= r_trk_cnt + 1'b1;
                2'b01:   r_trk_cnt <= r_trk_cnt - 1'b1;
                default: r_trk_cnt <= r_trk_cnt;
            endcase

            // Store acks retire silently; only loads produce a response pulse
            r_resp_valid <= w_ack & w_trk_head[TICKET_WIDTH];
            if (w_ack & w_trk_head[TICKET_WIDTH]) begin
                r_resp <= {w_trk_head[TICKET_WIDTH-1:0], w_rdata};
            end
        end
    end

endmodule
`default_nettype wire
